// File: rtl/slow_link_scheduler_pkg.sv
// Shared slow-link types: 128-bit frame payload and scheduler FSM states.
// No ports; imported by the interface, the arbiter user and the top.
package slow_link_scheduler_pkg;

    typedef logic [127:0] payload_t;

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        TICK      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_IDLE = 2'd3
    } state_e;

endpackage

// File: rtl/slow_link_scheduler_if.sv
// Requester and transmitter signals of the slow-link scheduler.
// master: requesters + transmitter side, slave: the scheduler itself.
interface slow_link_scheduler_if #(
    parameter int N_REQ = 4
);
    import slow_link_scheduler_pkg::*;

    logic [N_REQ-1:0]         req_valid_i;
    payload_t [N_REQ-1:0]     req_payload_i;
    logic [N_REQ-1:0]         req_ready_o;
    logic                     tx_idle_i;
    payload_t                 payload_o;
    logic                     frame_tick_o;
    logic [$clog2(N_REQ)-1:0] grant_id_o;
    logic                     keepalive_o;
    logic                     busy_o;
    logic                     start_err_o;

    modport master (
        output req_valid_i, req_payload_i, tx_idle_i,
        input  req_ready_o, payload_o, frame_tick_o,
        input  grant_id_o, keepalive_o, busy_o, start_err_o
    );

    modport slave (
        input  req_valid_i, req_payload_i, tx_idle_i,
        output req_ready_o, payload_o, frame_tick_o,
        output grant_id_o, keepalive_o, busy_o, start_err_o
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: search starts at last_i + 1.
// Ports: req_i request vector, last_i last winner; gnt_o one-hot, idx_o, any_o.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);
    localparam int W = $clog2(N);

    logic [W-1:0] j;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = '0;
        for (int i = 1; i <= N; i++) begin
            j = W'((int'(last_i) + i) % N);
            if (!any_o && req_i[j]) begin
                any_o    = 1'b1;
                gnt_o[j] = 1'b1;
                idx_o    = j;
            end
        end
    end

endmodule

// File: rtl/slow_link_scheduler.sv
// Shares one slow-link transmitter among N_REQ requesters, with keep-alive
// frames and a start timeout. Ports: clk, reset (sync, active-high), bus.
module slow_link_scheduler
    import slow_link_scheduler_pkg::*;
#(
    parameter int N_REQ            = 4,
    parameter int KEEPALIVE_CYCLES = 250000,
    parameter int START_TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    slow_link_scheduler_if.slave  bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int KW = $clog2(KEEPALIVE_CYCLES + 1);
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [KW-1:0] KA_LAST  = KW'(KEEPALIVE_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);

    state_e        state_q, state_d;
    payload_t      payload_q, payload_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;
    logic          ka_flag_q, ka_flag_d;
    logic          tick_q, tick_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;
    logic [KW-1:0] ka_cnt_q, ka_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [N_REQ-1:0] ready;

    logic [N_REQ-1:0] gnt;
    logic [IW-1:0]    gnt_idx;
    logic             gnt_any;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req_i  (bus.req_valid_i),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (gnt_idx),
        .any_o  (gnt_any)
    );

    always_comb begin
        state_d   = state_q;
        payload_d = payload_q;
        grant_d   = grant_q;
        last_d    = last_q;
        ka_flag_d = ka_flag_q;
        ka_cnt_d  = ka_cnt_q;
        tmo_d     = tmo_q;
        tick_d    = 1'b0;
        err_d     = 1'b0;
        ready     = '0;
        unique case (state_q)
            ARB: begin
                if (bus.tx_idle_i && gnt_any) begin
                    ready     = gnt;
                    payload_d = bus.req_payload_i[gnt_idx];
                    grant_d   = gnt_idx;
                    last_d    = gnt_idx;
                    ka_flag_d = 1'b0;
                    ka_cnt_d  = '0;
                    tick_d    = 1'b1;
                    state_d   = TICK;
                end else if (bus.tx_idle_i && ka_cnt_q == KA_LAST) begin
                    payload_d = '0;
                    ka_flag_d = 1'b1;
                    ka_cnt_d  = '0;
                    tick_d    = 1'b1;
                    state_d   = TICK;
                end else if (ka_cnt_q != KA_LAST) begin
                    // saturate so a busy link still fires once it idles
                    ka_cnt_d = ka_cnt_q + 1'b1;
                end
            end
            TICK: begin
                // the tick cycle counts as the first timeout cycle
                ka_cnt_d = '0;
                tmo_d    = TW'(1);
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!bus.tx_idle_i) begin
                    state_d = WAIT_IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ARB;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (bus.tx_idle_i) begin
                    state_d = ARB;
                end
            end
        endcase
        busy_d = (state_d != ARB);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB;
            payload_q <= '0;
            grant_q   <= '0;
            last_q    <= IW'(N_REQ - 1);
            ka_flag_q <= 1'b0;
            ka_cnt_q  <= '0;
            tmo_q     <= '0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            payload_q <= payload_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            ka_flag_q <= ka_flag_d;
            ka_cnt_q  <= ka_cnt_d;
            tmo_q     <= tmo_d;
            tick_q    <= tick_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    // reset kills strobes in the very cycle it is raised
    assign bus.req_ready_o  = reset ? '0 : ready;
    assign bus.frame_tick_o = tick_q & ~reset;
    assign bus.payload_o    = payload_q;
    assign bus.grant_id_o   = grant_q;
    assign bus.keepalive_o  = ka_flag_q;
    assign bus.busy_o       = busy_q;
    assign bus.start_err_o  = err_q;

endmodule
